uart_tx_framed: RTL
===================

Name: uart_tx_framed

Overview:
Parametrised successor to the team's fixed 8N1 UART transmitter.
- Supports 5–9 data bits, none/even/odd parity and 1 or 2 stop bits.
- Adds a one-entry holding buffer with a ready/valid handshake, so frames go out back-to-back with no idle gap.
- Sits between SPI/control logic and the board's UART TX pin.

Parameters:
- CLKS_PER_BIT, 104: clocks per serial bit (clock frequency / baud); legal range >= 2.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame; 1 or 2.

Ports:
- i_Clock  in  1  system clock; all logic on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Tx_DV  in  1  input byte valid; a transfer occurs when i_Tx_DV and o_Tx_Ready are both high on a rising edge.
- i_Tx_Byte  in  DATA_BITS  data to send; sampled on the transfer edge.
- o_Tx_Ready  out  1  holding buffer empty; may accept a word.
- o_Tx_Active  out  1  a frame is on the line.
- o_Tx_Serial  out  1  registered serial output; idles high.
- o_Tx_Done  out  1  one-cycle pulse per completed frame.

Behaviour:
- Reset (synchronous, i_Reset high at an edge):
  - Next cycle: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1.
  - State=IDLE, holding buffer empty, bit counter and clock counter = 0.
  - Reset mid-frame aborts the frame; the line goes high on the next cycle; no Done pulse.
- Storage: shift register (current frame) plus holding register with valid flag. o_Tx_Ready = !hold_valid (combinational from the flag).
- Transfer routing:
  - In IDLE, a transfer loads the shift register directly; the holding register stays empty.
  - In any other state, a transfer fills the holding register.
- States: IDLE -> START -> DATA -> [PARITY if PARITY != 0] -> STOP -> IDLE or START.
- Bit timing:
  - Every bit (start, data, parity, each stop) holds o_Tx_Serial for exactly CLKS_PER_BIT cycles.
  - Clock counter runs 0..CLKS_PER_BIT-1; width is $clog2(CLKS_PER_BIT).
- Latency: the start bit (0) appears on o_Tx_Serial on the cycle after the transfer edge in IDLE.
- DATA: LSB first, DATA_BITS bits; bit index wraps to 0 on leaving DATA.
- Parity bit:
  - Even: XOR of all data bits.
  - Odd: inverted XOR.
  - Computed from the shift-register contents latched at frame start.
- STOP: line=1 for STOP_BITS * CLKS_PER_BIT cycles.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- End of the last stop-bit cycle:
  - o_Tx_Done pulses high for exactly the next cycle.
  - If hold_valid: the shift register loads from hold, hold is cleared, and the next cycle drives the start bit. No idle bit between frames.
  - Else, if a transfer occurs on that same edge: that word goes directly to the shift register and START follows the next cycle (also no gap).
  - Else: go to IDLE; line stays high.
- o_Tx_Active:
  - High from the first start-bit cycle through the last stop-bit cycle.
  - Stays high continuously across back-to-back frames.
  - Goes low in the Done cycle when no frame follows.
- Holding buffer full: o_Tx_Ready=0; i_Tx_DV is ignored (no transfer, no data corruption).
- Simultaneous transfer and buffer drain at frame end, with hold full: no transfer is possible since ready=0; new data waits until the next cycle.
- Data-width rule: i_Tx_Byte width equals DATA_BITS exactly; no padding or truncation.
- Elaboration: an illegal parameter (DATA_BITS outside 5..9, STOP_BITS not 1/2, PARITY > 2, CLKS_PER_BIT < 2) triggers a synthesis-time error.

Test Plan:
1. Default 8N1, CLKS_PER_BIT=4, single transfer 0xA5 -> start=0, then bits 1,0,1,0,0,1,0,1, then stop=1. Each bit lasts 4 cycles; 40-cycle frame. Done pulses once, on cycle 41 after the transfer edge. Active=1 for cycles 1–40.
2. DATA_BITS=7, PARITY=1 (even), STOP_BITS=2, byte 0x53 (popcount 4) -> parity bit 0, two stop bits, frame = 11*CLKS_PER_BIT. Repeat with PARITY=2 -> parity bit 1.
3. Back-to-back: transfer 0x11, then 0x22 while the first frame runs, then assert i_Tx_DV with 0x33 while hold is full.
   - Ready drops after 0x22 is taken.
   - 0x33 is not accepted until the first frame's Done.
   - The 0x22 start bit immediately follows the 0x11 stop bit with zero idle cycles.
   - Active stays high across frames.
   - One Done pulse per frame.
4. Frame-end transfer: in IDLE-pending condition (hold empty), assert a transfer exactly on the last stop-bit edge -> next frame starts the following cycle with no gap.
5. Reset mid-DATA (bit index 3) with hold full -> next cycle: line=1, Active=0, Ready=1, no Done pulse. A subsequent transfer of 0x0F produces a clean frame.
6. Idle stability: 1000 cycles with no i_Tx_DV after reset -> Serial=1, Active=0, Done=0, Ready=1 throughout.

Source files
------------

// File: rtl/uart_tx_framed_if.sv
// Byte-stream handshake between a word producer and the framed UART transmitter.
// Both sides share these signals through the master/slave modports.
interface uart_tx_framed_if #(
  parameter int DATA_BITS = 8
);
  // A word moves on a rising edge where i_Tx_DV and o_Tx_Ready are both high.
  // i_Tx_Byte is sampled on that edge only. While o_Tx_Ready is low, i_Tx_DV is ignored.
  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Ready;
  logic                 o_Tx_Active;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Done;
  logic [2:0]           o_Dbg_State;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Dbg_State
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Dbg_State
  );
endinterface

// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter: 5..9 data bits, optional parity, 1/2 stop bits.
// A one-word holding register lets frames go out back-to-back with no idle bit.
module uart_tx_framed #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input logic             i_Clock,
  input logic             i_Reset,
  uart_tx_framed_if.slave tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = 1'(PARITY == 2);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_framed: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_framed: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_framed: PARITY must be 0, 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_framed: CLKS_PER_BIT must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_valid_q;
  logic                 parity_q;
  logic                 serial_q;
  logic                 active_q;
  logic                 done_q;

  logic xfer;
  logic bit_end;
  logic last_stop;
  logic frame_end;

  assign xfer      = tx.i_Tx_DV && !hold_valid_q;
  assign bit_end   = (cnt_q == CNT_LAST);
  assign last_stop = (stop_q == STOP_LAST);
  assign frame_end = (state_q == S_STOP) && bit_end && last_stop;

  function automatic logic par_of(input logic [DATA_BITS-1:0] w);
    return (^w) ^ ODD_PAR;
  endfunction

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      parity_q     <= 1'b0;
      serial_q     <= 1'b1;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A word arriving mid-frame parks in hold, except on the frame-end edge where it goes straight out.
      if (state_q != S_IDLE && xfer && !frame_end) begin
        hold_q       <= tx.i_Tx_Byte;
        hold_valid_q <= 1'b1;
      end
      if (state_q == S_IDLE) begin
        cnt_q <= '0;
        if (xfer) begin
          shift_q  <= tx.i_Tx_Byte;
          parity_q <= par_of(tx.i_Tx_Byte);
          state_q  <= S_START;
          serial_q <= 1'b0;
          active_q <= 1'b1;
        end
      end else if (!bit_end) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
        case (state_q)
          S_START: begin
            state_q  <= S_DATA;
            serial_q <= shift_q[0];
            bit_q    <= '0;
          end
          S_DATA: begin
            if (bit_q == BIT_LAST) begin
              bit_q <= '0;
              if (PARITY != 0) begin
                state_q  <= S_PARITY;
                serial_q <= parity_q;
              end else begin
                state_q  <= S_STOP;
                serial_q <= 1'b1;
                stop_q   <= 1'b0;
              end
            end else begin
              bit_q    <= bit_q + 1'b1;
              shift_q  <= shift_q >> 1;
              serial_q <= shift_q[1];
            end
          end
          S_PARITY: begin
            state_q  <= S_STOP;
            serial_q <= 1'b1;
            stop_q   <= 1'b0;
          end
          S_STOP: begin
            if (!last_stop) begin
              stop_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
              stop_q <= 1'b0;
              if (hold_valid_q) begin
                shift_q      <= hold_q;
                parity_q     <= par_of(hold_q);
                hold_valid_q <= 1'b0;
                state_q      <= S_START;
                serial_q     <= 1'b0;
              end else if (xfer) begin
                shift_q  <= tx.i_Tx_Byte;
                parity_q <= par_of(tx.i_Tx_Byte);
                state_q  <= S_START;
                serial_q <= 1'b0;
              end else begin
                state_q  <= S_IDLE;
                serial_q <= 1'b1;
                active_q <= 1'b0;
              end
            end
          end
          default: begin
            state_q  <= S_IDLE;
            serial_q <= 1'b1;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx.o_Tx_Ready  = !hold_valid_q;
  assign tx.o_Tx_Active = active_q;
  assign tx.o_Tx_Serial = serial_q;
  assign tx.o_Tx_Done   = done_q;
  assign tx.o_Dbg_State = state_q;
endmodule
